puf_eval_ctrl: RTL and testbench

- Downstream measurement/response stage of the ring-oscillator PUF. It consumes the two challenge-selected oscillator outputs (mux outputs of the two oscillator banks).
- Replaces free-running, asynchronously clocked counters with clk-domain counting over a programmable window.
- Sequences RESP_BITS consecutive challenges and packs the per-challenge comparison bits into one response word behind a start/done handshake.

---
 rtl/puf_eval_ctrl.sv | 146 ++++++++++++++
 tb/tb_puf_eval_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: ring-oscillator PUF measurement sequencer and response packer
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   i_start               request an evaluation (honoured only when idle)
//   i_base_chal           first challenge, latched on accept
//   i_window              measurement length in cycles, latched on accept (0 acts as 1)
//   i_ro_a, i_ro_b        selected oscillator outputs, asynchronous to clk
//   o_osc_en              oscillator enable for both banks
//   o_chal                current challenge to both mux selects
//   o_busy, o_done        evaluation in progress / one-cycle completion pulse
//   o_resp_valid          o_response holds a complete result
//   o_response            packed response, bit 0 belongs to the base challenge
//   o_tie                 some comparison of this evaluation was equal
//   o_cnt_a_last/_b_last  edge counts of the most recent comparison
module puf_eval_ctrl #(
    parameter int CHAL_W     = 5,
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int RESP_BITS  = 8,
    parameter int SETTLE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [CHAL_W-1:0]    i_base_chal,
    input  logic [WIN_W-1:0]     i_window,
    input  logic                 i_ro_a,
    input  logic                 i_ro_b,
    output logic                 o_osc_en,
    output logic [CHAL_W-1:0]    o_chal,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_resp_valid,
    output logic [RESP_BITS-1:0] o_response,
    output logic                 o_tie,
    output logic [CNT_W-1:0]     o_cnt_a_last,
    output logic [CNT_W-1:0]     o_cnt_b_last
);
    localparam int IDX_W = RESP_BITS > 1 ? $clog2(RESP_BITS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_MEASURE, S_COMPARE, S_DONE} state_t;

    state_t                 r_state, w_next;
    logic [WIN_W-1:0]       r_win_m1, r_cyc;
    logic [IDX_W-1:0]       r_idx;
    logic [2:0]             r_sync_a, r_sync_b;
    logic [CNT_W-1:0]       r_cnt_a, r_cnt_b, r_cnt_a_last, r_cnt_b_last;
    logic [CHAL_W-1:0]      r_chal;
    logic [RESP_BITS-1:0]   r_response;
    logic                   r_tie, r_resp_valid;
    logic                   w_edge_a, w_edge_b, w_settle_end, w_meas_end, w_last, w_accept;

    // bits [1:0] form the synchronizer, bit 2 is the previous synchronized sample
    assign w_edge_a     = r_sync_a[1] & ~r_sync_a[2];
    assign w_edge_b     = r_sync_b[1] & ~r_sync_b[2];
    assign w_settle_end = r_cyc == WIN_W'(SETTLE_CYC - 1);
    assign w_meas_end   = r_cyc == r_win_m1;
    assign w_last       = r_idx == IDX_W'(RESP_BITS - 1);
    assign w_accept     = (r_state == S_IDLE) && i_start;

    assign o_chal       = r_chal;
    assign o_response   = r_response;
    assign o_tie        = r_tie;
    assign o_resp_valid = r_resp_valid;
    assign o_cnt_a_last = r_cnt_a_last;
    assign o_cnt_b_last = r_cnt_b_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        o_osc_en = 1'b0;
        o_done   = 1'b0;
        o_busy   = r_state != S_IDLE;
        case (r_state)
            S_IDLE:    w_next = i_start ? S_SETTLE : S_IDLE;
            S_SETTLE: begin
                o_osc_en = 1'b1;
                w_next   = w_settle_end ? S_MEASURE : S_SETTLE;
            end
            S_MEASURE: begin
                o_osc_en = 1'b1;
                w_next   = w_meas_end ? S_COMPARE : S_MEASURE;
            end
            S_COMPARE: w_next = w_last ? S_DONE : S_SETTLE;
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_a     <= '0;
            r_sync_b     <= '0;
            r_cyc        <= '0;
            r_win_m1     <= '0;
            r_idx        <= '0;
            r_cnt_a      <= '0;
            r_cnt_b      <= '0;
            r_cnt_a_last <= '0;
            r_cnt_b_last <= '0;
            r_chal       <= '0;
            r_response   <= '0;
            r_tie        <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            r_sync_a <= {r_sync_a[1:0], i_ro_a};
            r_sync_b <= {r_sync_b[1:0], i_ro_b};
            // phase timer restarts on every state change
            r_cyc    <= (w_next != r_state) ? '0 : r_cyc + WIN_W'(1);
            if (r_state == S_SETTLE) begin
                r_cnt_a <= '0;
                r_cnt_b <= '0;
            end else if (r_state == S_MEASURE) begin
                r_cnt_a <= r_cnt_a + CNT_W'(w_edge_a & ~&r_cnt_a);
                r_cnt_b <= r_cnt_b + CNT_W'(w_edge_b & ~&r_cnt_b);
            end
            if (w_accept) begin
                r_chal       <= i_base_chal;
                r_win_m1     <= (i_window == '0) ? '0 : i_window - WIN_W'(1);
                r_response   <= '0;
                r_tie        <= 1'b0;
                r_resp_valid <= 1'b0;
                r_idx        <= '0;
            end
            if (r_state == S_COMPARE) begin
                r_response[r_idx] <= r_cnt_a > r_cnt_b;
                r_tie             <= r_tie | (r_cnt_a == r_cnt_b);
                r_cnt_a_last      <= r_cnt_a;
                r_cnt_b_last      <= r_cnt_b;
                if (w_last) begin
                    r_resp_valid <= 1'b1;
                end else begin
                    r_idx  <= r_idx + IDX_W'(1);
                    r_chal <= r_chal + CHAL_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb_puf_eval_ctrl: randomized and directed bench for puf_eval_ctrl against a challenge-to-period oscillator model
module tb_puf_eval_ctrl;
    localparam int LIMIT = 10000;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [4:0]  base_chal = '0;
    logic [15:0] window = 16'd16;
    logic        ro_a = 1'b0, ro_b = 1'b0;

    logic        osc_en, busy, done, resp_valid, tie;
    logic [4:0]  chal;
    logic [7:0]  response;
    logic [15:0] cnt_a_last, cnt_b_last;

    logic        s_osc_en, s_busy, s_done, s_resp_valid, s_tie;
    logic [4:0]  s_chal;
    logic [7:0]  s_response, s_cnt_a_last, s_cnt_b_last;

    int          tests = 0, fails = 0;
    int          per_a[32], per_b[32];
    int          ph_a = 0, ph_b = 0;
    logic [4:0]  chal_seq[$];

    puf_eval_ctrl dut (
        .clk(clk), .reset(reset), .i_start(start), .i_base_chal(base_chal), .i_window(window),
        .i_ro_a(ro_a), .i_ro_b(ro_b), .o_osc_en(osc_en), .o_chal(chal), .o_busy(busy),
        .o_done(done), .o_resp_valid(resp_valid), .o_response(response), .o_tie(tie),
        .o_cnt_a_last(cnt_a_last), .o_cnt_b_last(cnt_b_last)
    );

    puf_eval_ctrl #(.CNT_W(8)) dut_sat (
        .clk(clk), .reset(reset), .i_start(start), .i_base_chal(base_chal), .i_window(window),
        .i_ro_a(ro_a), .i_ro_b(ro_b), .o_osc_en(s_osc_en), .o_chal(s_chal), .o_busy(s_busy),
        .o_done(s_done), .o_resp_valid(s_resp_valid), .o_response(s_response), .o_tie(s_tie),
        .o_cnt_a_last(s_cnt_a_last), .o_cnt_b_last(s_cnt_b_last)
    );

    always #5 clk = ~clk;

    // oscillator model: each challenge selects a period (in clk cycles) per bank, 0 = stuck low
    initial forever begin
        @(posedge clk);
        #2;
        if (per_a[chal] == 0) begin ro_a = 1'b0; ph_a = 0; end
        else if (++ph_a >= per_a[chal] / 2) begin ph_a = 0; ro_a = ~ro_a; end
        if (per_b[chal] == 0) begin ro_b = 1'b0; ph_b = 0; end
        else if (++ph_b >= per_b[chal] / 2) begin ph_b = 0; ro_b = ~ro_b; end
    end

    function automatic logic [7:0] model_resp(input logic [4:0] b);
        logic [7:0] r = '0;
        for (int k = 0; k < 8; k++) begin
            int c = (b + k) % 32;
            r[k] = per_a[c] != 0 && (per_b[c] == 0 || per_a[c] < per_b[c]);
        end
        return r;
    endfunction

    function automatic logic model_tie(input logic [4:0] b);
        logic t = 1'b0;
        for (int k = 0; k < 8; k++) t |= per_a[(b + k) % 32] == per_b[(b + k) % 32];
        return t;
    endfunction

    function automatic logic seq_ok(input logic [4:0] b);
        logic ok = chal_seq.size() == 8;
        for (int k = 0; k < 8 && ok; k++) ok = chal_seq[k] == 5'((b + k) % 32);
        return ok;
    endfunction

    task automatic set_per(input int pa, input int pb);
        for (int c = 0; c < 32; c++) begin per_a[c] = pa; per_b[c] = pb; end
        ph_a = 0; ph_b = 0; ro_a = 1'b0; ro_b = 1'b0;
    endtask

    // entered at the negedge after an accept; leaves at the negedge where done is seen
    task automatic wait_done(input int pulse_at, input bit hold, output int lat);
        lat = 0;
        chal_seq.delete();
        while (!done && lat < LIMIT) begin
            if (chal_seq.size() == 0 || chal_seq[$] != chal) chal_seq.push_back(chal);
            start = hold || (lat == pulse_at);
            if (lat == pulse_at) base_chal = ~base_chal;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL timeout: done not seen after %0d cycles", lat);
        end
    endtask

    task automatic run_eval(input logic [4:0] b, input logic [15:0] w, input int pulse_at,
                            input bit hold, output int lat);
        @(negedge clk);
        base_chal = b; window = w; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wait_done(pulse_at, hold, lat);
    endtask

    task automatic test_reset();
        int lat;
        repeat (2) @(negedge clk);
        tests++;
        if ({osc_en, busy, done, resp_valid, tie, chal, response, cnt_a_last, cnt_b_last} !== '0) begin
            fails++; $display("FAIL por_outputs: got osc_en=%0b busy=%0b done=%0b rv=%0b resp=%0h chal=%0d, expected all 0",
                              osc_en, busy, done, resp_valid, response, chal);
        end
        reset = 1'b0;
        set_per(4, 8);
        @(negedge clk);
        base_chal = 5'd0; window = 16'd16; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (31) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({osc_en, busy, response[0], chal} !== {1'b1, 1'b1, 1'b1, 5'd1}) begin
            fails++; $display("FAIL midmeasure_pre: got osc_en=%0b busy=%0b resp0=%0b chal=%0d, expected 1 1 1 1",
                              osc_en, busy, response[0], chal);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({osc_en, busy, resp_valid, response, chal, cnt_a_last, tie} !== '0) begin
            fails++; $display("FAIL async_reset: got osc_en=%0b busy=%0b rv=%0b resp=%0h chal=%0d cnt_a=%0d, expected all 0",
                              osc_en, busy, resp_valid, response, chal, cnt_a_last);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_eval(5'd0, 16'd16, -1, 1'b0, lat);
        tests++;
        if ({lat, response} !== {32'd168, 8'hFF}) begin
            fails++; $display("FAIL after_reset: got lat=%0d resp=%0h, expected 168 ff", lat, response);
        end
    endtask

    task automatic test_clear_winner();
        int lat;
        set_per(4, 8);
        run_eval(5'd3, 16'd16, -1, 1'b0, lat);
        tests++;
        if (lat !== 168) begin fails++; $display("FAIL cw_latency: got %0d expected 168", lat); end
        tests++;
        if ({response, tie, resp_valid} !== {model_resp(5'd3), model_tie(5'd3), 1'b1}) begin
            fails++; $display("FAIL cw_response: got resp=%0h tie=%0b rv=%0b expected resp=%0h tie=%0b rv=1",
                              response, tie, resp_valid, model_resp(5'd3), model_tie(5'd3));
        end
        tests++;
        if (cnt_a_last < 3 || cnt_a_last > 5 || cnt_b_last < 1 || cnt_b_last > 3) begin
            fails++; $display("FAIL cw_counts: got a=%0d b=%0d expected a=4+-1 b=2+-1", cnt_a_last, cnt_b_last);
        end
        tests++;
        if (!seq_ok(5'd3)) begin
            fails++; $display("FAIL cw_chal_seq: got %0d values starting %0d, expected 3..10", chal_seq.size(), chal_seq[0]);
        end
    endtask

    task automatic test_swapped();
        int lat;
        set_per(8, 4);
        run_eval(5'd12, 16'd16, -1, 1'b0, lat);
        tests++;
        if ({response, tie} !== {model_resp(5'd12), model_tie(5'd12)}) begin
            fails++; $display("FAIL swapped: got resp=%0h tie=%0b expected resp=%0h tie=%0b",
                              response, tie, model_resp(5'd12), model_tie(5'd12));
        end
    endtask

    task automatic test_tie_wrap();
        int lat;
        set_per(0, 0);
        run_eval(5'd30, 16'd16, -1, 1'b0, lat);
        tests++;
        if ({response, tie, cnt_a_last, cnt_b_last} !== {8'h00, 1'b1, 32'd0}) begin
            fails++; $display("FAIL tie: got resp=%0h tie=%0b a=%0d b=%0d expected 00 1 0 0",
                              response, tie, cnt_a_last, cnt_b_last);
        end
        tests++;
        if (!seq_ok(5'd30)) begin
            fails++; $display("FAIL wrap_chal_seq: got %0d values, last %0d, expected 30,31,0..5", chal_seq.size(), chal_seq[$]);
        end
    endtask

    task automatic test_handshake();
        int lat;
        set_per(4, 8);
        run_eval(5'd7, 16'd0, 10, 1'b0, lat);
        tests++;
        if (lat !== 48) begin fails++; $display("FAIL win0_latency: got %0d expected 48", lat); end
        tests++;
        if (!seq_ok(5'd7)) begin
            fails++; $display("FAIL start_ignored: got %0d chal values starting %0d, expected 7..14", chal_seq.size(), chal_seq[0]);
        end
        base_chal = 5'd1;
        run_eval(5'd1, 16'd0, -1, 1'b1, lat);
        tests++;
        if ({done, resp_valid} !== 2'b11) begin
            fails++; $display("FAIL held_done: got done=%0b rv=%0b expected 1 1", done, resp_valid);
        end
        @(negedge clk);
        tests++;
        if ({busy, resp_valid, done} !== 3'b010) begin
            fails++; $display("FAIL held_idle: got busy=%0b rv=%0b done=%0b expected 0 1 0", busy, resp_valid, done);
        end
        @(negedge clk);
        tests++;
        if ({busy, resp_valid} !== 2'b10) begin
            fails++; $display("FAIL held_accept: got busy=%0b rv=%0b expected 1 0", busy, resp_valid);
        end
        wait_done(-1, 1'b0, lat);
        tests++;
        if (lat !== 48) begin fails++; $display("FAIL held_latency: got %0d expected 48", lat); end
    endtask

    task automatic test_random();
        int lat, w, pl;
        logic [4:0] b;
        for (int n = 0; n < 3; n++) begin
            for (int c = 0; c < 32; c++) begin
                int fast = 2 * $urandom_range(1, 2);
                int slow = 2 * $urandom_range(6, 8);
                if ($urandom_range(0, 1) == 1) begin per_a[c] = fast; per_b[c] = slow; end
                else begin per_a[c] = slow; per_b[c] = fast; end
            end
            w = $urandom_range(32, 64);
            b = 5'($urandom_range(0, 31));
            run_eval(b, 16'(w), -1, 1'b0, lat);
            tests++;
            if (lat !== 8 * (w + 5)) begin fails++; $display("FAIL rnd_latency: got %0d expected %0d", lat, 8 * (w + 5)); end
            tests++;
            if ({response, tie} !== {model_resp(b), model_tie(b)}) begin
                fails++; $display("FAIL rnd_response: got resp=%0h tie=%0b expected resp=%0h tie=%0b (base %0d win %0d)",
                                  response, tie, model_resp(b), model_tie(b), b, w);
            end
            tests++;
            if (!seq_ok(b)) begin fails++; $display("FAIL rnd_chal_seq: got %0d values expected 8 from %0d", chal_seq.size(), b); end
            pl = per_a[(b + 7) % 32];
            tests++;
            if (int'(cnt_a_last) < w / pl - 2 || int'(cnt_a_last) > w / pl + 2) begin
                fails++; $display("FAIL rnd_cnt_a: got %0d expected about %0d", cnt_a_last, w / pl);
            end
        end
    endtask

    task automatic test_saturation();
        int lat;
        set_per(2, 2);
        run_eval(5'd9, 16'd600, -1, 1'b0, lat);
        tests++;
        if (lat !== 4840) begin fails++; $display("FAIL sat_latency: got %0d expected 4840", lat); end
        tests++;
        if ({s_done, s_cnt_a_last, s_cnt_b_last, s_tie, s_response} !== {1'b1, 8'd255, 8'd255, 1'b1, 8'h00}) begin
            fails++; $display("FAIL sat_counts: got done=%0b a=%0d b=%0d tie=%0b resp=%0h expected 1 255 255 1 00",
                              s_done, s_cnt_a_last, s_cnt_b_last, s_tie, s_response);
        end
        tests++;
        if (cnt_a_last < 299 || cnt_a_last > 301 || cnt_b_last !== cnt_a_last || tie !== 1'b1) begin
            fails++; $display("FAIL wide_counts: got a=%0d b=%0d tie=%0b expected a=b=300+-1 tie=1",
                              cnt_a_last, cnt_b_last, tie);
        end
    endtask

    initial begin
        set_per(0, 0);
        test_reset();
        test_clear_winner();
        test_swapped();
        test_tie_wrap();
        test_handshake();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
